pcs_10g_rx_sync: RTL and testbench
==================================

# pcs_10g_rx_sync

Receive-side 64b/66b gearbox with block-lock state machine for the 10G PCS. It sits between the PMA deserializer and the descrambler/decoder. It takes 32 raw line bits per cycle and reassembles 66-bit blocks, emitted as a head half (2-bit sync header plus 32 data bits) followed by a tail half (32 data bits). It acquires and maintains block alignment using the clause-49-style bit-slip lock procedure. It is the inverse of the transmit gearbox, which inserts one idle cycle every 33.

## Interface
Parameters:
- DATA_W, 32, line bits in and data bits out per cycle; only 32 is supported.
- HEAD_W, 2, sync header width.
- LOCK_CNT, 64, headers per test window.
- INVALID_MAX, 16, invalid headers per window that cause loss of lock.

Ports:
- clk  in  1  clock.
- nreset  in  1  synchronous, active-low reset.
- data_i  in  32  raw line bits; bit 0 is the earliest on the wire. One word is accepted every cycle, with no backpressure.
- valid_o  out  1  data_o (and head_o when head_v_o=1) is valid this cycle.
- head_v_o  out  1  the current output is a head half; implies valid_o.
- head_o  out  2  sync header; head_o[0] is the earlier bit. Meaningful only when head_v_o=1.
- data_o  out  32  payload half-block; data_o[0] is the earliest bit.
- lock_o  out  1  block lock achieved; downstream ignores data while this is 0.
- slip_o  out  1  one-cycle pulse; one bit is discarded from the buffer in this cycle.

## Operation
- Bit buffer: 64 bits, LSB = oldest bit. Occupancy count cnt_q is 7 bits.
- Each cycle, in order:
  - If slip_o=1, drop the oldest buffered bit (cnt -1).
  - Append data_i above the remaining bits: avail = cnt + 32.
  - Extract per phase_q:
    - HEAD phase needs 34 bits: head = bits[1:0], data = bits[33:2].
    - TAIL phase needs 32 bits: data = bits[31:0].
  - If avail >= need: consume those bits, register the outputs, and toggle phase_q.
  - Otherwise: no output; the bits are retained and phase_q is unchanged (stall).
- Steady state is 32 outputs (16 blocks) and then one stall, giving a 33-cycle period. Maximum avail is 64, so the buffer never overflows.
- A header is valid iff head_o[0] != head_o[1].
- Lock FSM counters: sh_cnt (7 bits) and inv_cnt (5 bits). The FSM is evaluated on cycles with head_v_o=1, using the registered head_o.
- Lock FSM states:
  - UNLOCKED:
    - Invalid header: set slip_o the next cycle and clear both counters.
    - Valid header: sh_cnt+1.
    - sh_cnt reaching LOCK_CNT: go to LOCKED (lock_o=1 the next cycle) and clear counters.
  - LOCKED:
    - Every header: sh_cnt+1.
    - Invalid header: inv_cnt+1.
    - inv_cnt reaching INVALID_MAX: go to UNLOCKED, lock_o=0 and slip_o=1 the next cycle, clear counters.
    - sh_cnt reaching LOCK_CNT with inv_cnt < INVALID_MAX: clear both counters and stay LOCKED.
- The phase does not reset on a slip. Header tests resume with the next head output.
- If the slip cycle is itself an extraction cycle, the drop happens before the extraction.
- Simultaneous events: if the LOCK_CNT and INVALID_MAX thresholds are hit on the same header, loss of lock wins.

## Timing
- Reset values: valid_o, head_v_o, lock_o, slip_o = 0; head_o = 0, data_o = 0. cnt_q = 0, phase_q = HEAD, FSM UNLOCKED, counters 0.
- Assertion of nreset at any time aborts the current operation, returns every register to its reset value and loses lock.
- Cycle numbering: cycle 0 is the first cycle after reset release.
  - Cycle 0: avail = 32, stall.
  - Cycle 1: extract the first head half; valid_o=head_v_o=1 in cycle 2 with:
    - head_o = data_i@0[1:0]
    - data_o = {data_i@1[1:0], data_i@0[31:2]}
  - Cycle 3 carries the tail half: data_o = {data_i@2[1:0], data_i@1[31:2]}.
  - First stall output: valid_o=0 in cycle 34.
- Latency from extraction to output is one register stage.
- lock_o and slip_o change one cycle after the head_v_o cycle that triggers them.

## Test plan
- Reset: hold nreset=0 for 3 cycles with random data_i -> all outputs 0 and cnt_q=0.
- Aligned stream: scrambled blocks with header 2'b10/2'b01 and no offset:
  - first head_v_o in cycle 2, and head_o/data_o bit-exact to the stimulus.
  - valid_o low exactly 1 cycle in every 33.
  - lock_o rises the cycle after the 64th head_v_o, with slip_o never asserted.
- Offset k=5 bits: slip_o pulses, each followed by at least one head test; lock_o rises after 64 consecutive valid headers, and data_o then matches the transmitted blocks bit-exact.
- Loss of lock:
  - While locked, corrupt 15 headers (to 2'b00) within one 64-header window -> lock_o stays 1.
  - Corrupt 16 -> lock_o=0 and a single slip_o pulse the cycle after the 16th bad header.
- Unlocked early error: one invalid header at the 40th head -> slip_o the next cycle and sh_cnt restarts; lock_o requires 64 further valid headers.
- Mid-run reset: assert nreset for 1 cycle while locked mid-block -> the next cycle shows reset values, and the sequence restarts with the first head in cycle 2 after release.

Source files
------------

// File: rtl/pcs_10g_rx_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : pcs_10g_rx_sync_if
// Brief    : Line-side input and half-block output bundle of the 10G RX gearbox.
// Revision : 1.0 - initial release
// ============================================================================
interface pcs_10g_rx_sync_if #(
    parameter int DATA_W = 32,
    parameter int HEAD_W = 2
);
    logic [DATA_W-1:0] data_i;
    logic              valid_o;
    logic              head_v_o;
    logic [HEAD_W-1:0] head_o;
    logic [DATA_W-1:0] data_o;
    logic              lock_o;
    logic              slip_o;

    modport master (
        output data_i,
        input  valid_o,
        input  head_v_o,
        input  head_o,
        input  data_o,
        input  lock_o,
        input  slip_o
    );

    modport slave (
        input  data_i,
        output valid_o,
        output head_v_o,
        output head_o,
        output data_o,
        output lock_o,
        output slip_o
    );
endinterface
`default_nettype wire

// File: rtl/pcs_10g_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : pcs_10g_rx_sync
// Brief    : 10G PCS receive 64b/66b gearbox with bit-slip block-lock FSM.
// Revision : 1.0 - initial release
// ============================================================================
module pcs_10g_rx_sync #(
    parameter int DATA_W      = 32,
    parameter int HEAD_W      = 2,
    parameter int LOCK_CNT    = 64,
    parameter int INVALID_MAX = 16
) (
    input  wire logic        clk,
    input  wire logic        nreset,
    pcs_10g_rx_sync_if.slave bus
);
    localparam int         C_BUF_W       = 2 * DATA_W;
    // An odd slip count can leave 33 bits buffered, so the merge needs 65 bits.
    localparam int         C_WORK_W      = 2 * DATA_W + HEAD_W;
    localparam logic [6:0] C_HEAD_NEED   = 7'(DATA_W + HEAD_W);
    localparam logic [6:0] C_TAIL_NEED   = 7'(DATA_W);
    localparam logic [6:0] C_LOCK_CNT    = 7'(LOCK_CNT);
    localparam logic [4:0] C_INVALID_MAX = 5'(INVALID_MAX);

    localparam logic [0:0] C_PH_HEAD     = 1'b0;
    localparam logic [0:0] C_PH_TAIL     = 1'b1;
    localparam logic [0:0] C_ST_UNLOCKED = 1'b0;
    localparam logic [0:0] C_ST_LOCKED   = 1'b1;

    logic [C_BUF_W-1:0]  r_buf;
    logic [6:0]          r_cnt;
    logic [0:0]          r_phase;
    logic                r_valid;
    logic                r_head_v;
    logic [HEAD_W-1:0]   r_head;
    logic [DATA_W-1:0]   r_data;
    logic [0:0]          r_state;
    logic [6:0]          r_sh_cnt;
    logic [4:0]          r_inv_cnt;
    logic                r_slip;

    logic [C_WORK_W-1:0] w_work;
    logic [C_BUF_W-1:0]  w_buf_nxt;
    logic [6:0]          w_avail;
    logic [6:0]          w_need;
    logic                w_take;
    logic                w_hdr_ok;
    logic [6:0]          w_sh_inc;
    logic [4:0]          w_inv_inc;

    // Slip drops the oldest bit of the merged vector, so it also works on an empty buffer.
    always_comb begin
        w_work  = {{(C_WORK_W - C_BUF_W){1'b0}}, r_buf}
                | ({{(C_WORK_W - DATA_W){1'b0}}, bus.data_i} << r_cnt);
        w_avail = r_cnt + 7'(DATA_W);
        if (r_slip) begin
            w_work  = w_work >> 1;
            w_avail = w_avail - 7'd1;
        end
        w_need    = (r_phase == C_PH_HEAD) ? C_HEAD_NEED : C_TAIL_NEED;
        w_take    = (w_avail >= w_need);
        w_buf_nxt = w_take ? C_BUF_W'(w_work >> w_need) : C_BUF_W'(w_work);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_buf    <= '0;
            r_cnt    <= '0;
            r_phase  <= C_PH_HEAD;
            r_valid  <= 1'b0;
            r_head_v <= 1'b0;
            r_head   <= '0;
            r_data   <= '0;
        end else begin
            r_buf    <= w_buf_nxt;
            r_valid  <= w_take;
            r_head_v <= w_take && (r_phase == C_PH_HEAD);
            if (w_take) begin
                r_cnt   <= w_avail - w_need;
                r_phase <= ~r_phase;
                if (r_phase == C_PH_HEAD) begin
                    r_head <= w_work[0 +: HEAD_W];
                    r_data <= w_work[HEAD_W +: DATA_W];
                end else begin
                    r_data <= w_work[0 +: DATA_W];
                end
            end else begin
                r_cnt <= w_avail;
            end
        end
    end

    // Header tests run on the registered head half, one cycle after extraction.
    assign w_hdr_ok  = r_head[0] ^ r_head[1];
    assign w_sh_inc  = r_sh_cnt + 7'd1;
    assign w_inv_inc = r_inv_cnt + {4'd0, ~w_hdr_ok};

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state   <= C_ST_UNLOCKED;
            r_sh_cnt  <= '0;
            r_inv_cnt <= '0;
            r_slip    <= 1'b0;
        end else begin
            r_slip <= 1'b0;
            if (r_head_v) begin
                case (r_state)
                    C_ST_UNLOCKED: begin
                        if (!w_hdr_ok) begin
                            r_slip    <= 1'b1;
                            r_sh_cnt  <= '0;
                            r_inv_cnt <= '0;
                        end else if (w_sh_inc == C_LOCK_CNT) begin
                            r_state   <= C_ST_LOCKED;
                            r_sh_cnt  <= '0;
                            r_inv_cnt <= '0;
                        end else begin
                            r_sh_cnt  <= w_sh_inc;
                        end
                    end
                    C_ST_LOCKED: begin
                        // Loss of lock takes priority over a window rollover on the same header.
                        if (w_inv_inc == C_INVALID_MAX) begin
                            r_state   <= C_ST_UNLOCKED;
                            r_slip    <= 1'b1;
                            r_sh_cnt  <= '0;
                            r_inv_cnt <= '0;
                        end else if (w_sh_inc == C_LOCK_CNT) begin
                            r_sh_cnt  <= '0;
                            r_inv_cnt <= '0;
                        end else begin
                            r_sh_cnt  <= w_sh_inc;
                            r_inv_cnt <= w_inv_inc;
                        end
                    end
                    default: begin
                        r_state <= C_ST_UNLOCKED;
                    end
                endcase
            end
        end
    end

    assign bus.valid_o  = r_valid;
    assign bus.head_v_o = r_head_v;
    assign bus.head_o   = r_head;
    assign bus.data_o   = r_data;
    assign bus.lock_o   = (r_state == C_ST_LOCKED);
    assign bus.slip_o   = r_slip;

endmodule
`default_nettype wire

// File: tb/tb_pcs_10g_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_10g_rx_sync
// Brief    : Directed self-checking bench for the 10G RX gearbox and block lock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_10g_rx_sync;
    localparam int NB    = 1000;
    localparam int NBITS = NB * 66 + 16;
    localparam int MAXH  = 2048;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    pcs_10g_rx_sync_if bus ();
    pcs_10g_rx_sync dut (.clk(clk), .nreset(nreset), .bus(bus));

    logic [1:0]  hdr   [NB];
    logic [63:0] pay   [NB];
    logic        sbits [NBITS];

    int n_pass = 0;
    int n_checks = 0;

    int nh, nslip, slip_c_first, slip_untested, run, run_at_rise;
    int lock_rise_c, lock_rise_nh, lock_fall_c, lock_fall_nh;
    int first_stall_c, nlow, exp_tail, chk_from, chk_to, blk_off;
    int head_cyc [MAXH];
    logic lock_prev, tested, slip_at_fall, slip_after_fall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic gen_blocks();
        for (int b = 0; b < NB; b++) begin
            hdr[b] = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            pay[b] = {$urandom, $urandom};
        end
    endtask

    // k junk bits lead the stream; a duplicate header bit is inserted before block ins.
    task automatic build_stream(input int k, input int ins);
        int p;
        p = 0;
        for (int i = 0; i < NBITS; i++) sbits[i] = 1'b0;
        for (int i = 0; i < k; i++) begin sbits[p] = 1'($urandom_range(0, 1)); p++; end
        for (int b = 0; b < NB && p + 67 <= NBITS; b++) begin
            if (b == ins) begin sbits[p] = hdr[b][0]; p++; end
            sbits[p] = hdr[b][0]; sbits[p+1] = hdr[b][1]; p += 2;
            for (int i = 0; i < 64; i++) begin sbits[p] = pay[b][i]; p++; end
        end
    endtask

    function automatic logic [31:0] word_at(input int c);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = sbits[32*c + i];
        return w;
    endfunction

    task automatic step(input logic rn, input logic [31:0] w);
        nreset = rn;
        bus.data_i = w;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_stats();
        nh = 0; nslip = 0; slip_c_first = -1; slip_untested = 0; run = 0; run_at_rise = -1;
        lock_rise_c = -1; lock_rise_nh = -1; lock_fall_c = -1; lock_fall_nh = -1;
        first_stall_c = -1; nlow = 0; exp_tail = -1; chk_from = 1; chk_to = 0; blk_off = 0;
        lock_prev = 1'b0; tested = 1'b0; slip_at_fall = 1'b0; slip_after_fall = 1'b1;
        for (int i = 0; i < MAXH; i++) head_cyc[i] = -1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom);
        reset_stats();
    endtask

    task automatic observe(input int oc);
        int b;
        if (bus.lock_o && !lock_prev && lock_rise_c < 0) begin
            lock_rise_c = oc; lock_rise_nh = nh; run_at_rise = run;
        end
        if (!bus.lock_o && lock_prev && lock_fall_c < 0) begin
            lock_fall_c = oc; lock_fall_nh = nh; slip_at_fall = bus.slip_o;
        end
        if (lock_fall_c >= 0 && oc == lock_fall_c + 1) slip_after_fall = bus.slip_o;
        lock_prev = bus.lock_o;
        if (bus.slip_o) begin
            nslip++;
            if (slip_c_first < 0) slip_c_first = oc;
            if (!tested) slip_untested++;
            tested = 1'b0;
        end
        if (bus.head_v_o) begin
            nh++;
            if (nh < MAXH) head_cyc[nh] = oc;
            tested = 1'b1;
            if (bus.head_o[0] != bus.head_o[1]) run++; else run = 0;
            b = nh - 1 + blk_off;
            if (nh >= chk_from && nh <= chk_to && b >= 0 && b < NB) begin
                check("head", 64'(bus.head_o), 64'(hdr[b]));
                check("data_head", 64'(bus.data_o), 64'(pay[b][31:0]));
                exp_tail = b;
            end else begin
                exp_tail = -1;
            end
        end else if (bus.valid_o) begin
            if (exp_tail >= 0) check("data_tail", 64'(bus.data_o), 64'(pay[exp_tail][63:32]));
            exp_tail = -1;
        end
        if (oc >= 2 && !bus.valid_o) begin
            if (first_stall_c < 0) first_stall_c = oc;
            if (oc < 134) nlow++;
        end
    endtask

    initial begin
        int  c;
        int  found;
        bit  mapped;

        // Reset with random line data
        bus.data_i = '0;
        nreset = 1'b0;
        gen_blocks();
        for (int b = 69; b <= 83; b++) hdr[b] = 2'b00;
        for (int b = 139; b <= 154; b++) hdr[b] = 2'b00;
        build_stream(0, -1);
        do_reset(3);
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_head_v", 64'(bus.head_v_o), 64'd0);
        check("rst_lock", 64'(bus.lock_o), 64'd0);
        check("rst_slip", 64'(bus.slip_o), 64'd0);
        check("rst_head", 64'(bus.head_o), 64'd0);
        check("rst_data", 64'(bus.data_o), 64'd0);
        check("rst_cnt", 64'(dut.r_cnt), 64'd0);

        // Aligned stream: lock, 15 bad headers tolerated, 16 bad lose lock
        chk_from = 1; chk_to = 154;
        for (c = 0; c < 600; c++) begin
            step(1'b1, word_at(c));
            observe(c + 1);
            if (lock_fall_c >= 0 && c + 1 >= lock_fall_c + 2) break;
        end
        check("first_head_cyc", 64'(head_cyc[1]), 64'd2);
        check("first_stall_cyc", 64'(first_stall_c), 64'd34);
        check("stalls_in_4_periods", 64'(nlow), 64'd4);
        check("lock_rise_heads", 64'(lock_rise_nh), 64'd64);
        check("lock_rise_cyc", 64'(lock_rise_c), 64'(head_cyc[64] + 1));
        check("lock_fall_heads", 64'(lock_fall_nh), 64'd155);
        check("lock_fall_cyc", 64'(lock_fall_c), 64'(head_cyc[155] + 1));
        check("first_slip_at_fall", 64'(slip_c_first), 64'(lock_fall_c));
        check("slip_at_fall", 64'(slip_at_fall), 64'd1);
        check("slip_single_pulse", 64'(slip_after_fall), 64'd0);

        // Offset of 5 bits: five slips, then lock and bit-exact data
        gen_blocks();
        build_stream(5, -1);
        do_reset(2);
        mapped = 1'b0;
        for (c = 0; c < 1500; c++) begin
            step(1'b1, word_at(c));
            observe(c + 1);
            if (lock_rise_c >= 0 && !mapped && bus.head_v_o) begin
                found = -1;
                for (int b = 0; b < NB; b++)
                    if (found < 0 && hdr[b] == bus.head_o && pay[b][31:0] == bus.data_o) found = b;
                mapped = 1'b1;
                check("k5_block_found", 64'(found >= 0), 64'd1);
                blk_off = found - (nh - 1);
                chk_from = nh + 1;
                chk_to = nh + 20;
            end
            if (mapped && nh > chk_to) break;
        end
        check("k5_locked", 64'(mapped), 64'd1);
        check("k5_slips", 64'(nslip), 64'd5);
        check("k5_slip_untested", 64'(slip_untested), 64'd0);
        check("k5_valid_run_at_lock", 64'(run_at_rise), 64'd64);
        check("k5_lock_cyc", 64'(lock_rise_c), 64'(head_cyc[lock_rise_nh] + 1));

        // Unlocked early error at head 40; slip realigns, 64 more valid heads to lock
        gen_blocks();
        build_stream(0, 39);
        do_reset(2);
        chk_from = 41; chk_to = 110;
        for (c = 0; c < 600; c++) begin
            step(1'b1, word_at(c));
            observe(c + 1);
            if (nh >= 112) break;
        end
        check("e_slips", 64'(nslip), 64'd1);
        check("e_slip_cyc", 64'(slip_c_first), 64'(head_cyc[40] + 1));
        check("e_lock_heads", 64'(lock_rise_nh), 64'd104);
        check("e_lock_cyc", 64'(lock_rise_c), 64'(head_cyc[104] + 1));

        // Mid-run reset while locked, between head and tail halves
        gen_blocks();
        build_stream(0, -1);
        do_reset(2);
        chk_from = 1; chk_to = 200;
        for (c = 0; c < 400; c++) begin
            step(1'b1, word_at(c));
            observe(c + 1);
            if (nh == 70 && bus.head_v_o) break;
        end
        check("mrst_locked_before", 64'(bus.lock_o), 64'd1);
        step(1'b0, word_at(c + 1));
        check("mrst_valid", 64'(bus.valid_o), 64'd0);
        check("mrst_head_v", 64'(bus.head_v_o), 64'd0);
        check("mrst_lock", 64'(bus.lock_o), 64'd0);
        check("mrst_slip", 64'(bus.slip_o), 64'd0);
        check("mrst_head", 64'(bus.head_o), 64'd0);
        check("mrst_data", 64'(bus.data_o), 64'd0);
        reset_stats();
        chk_from = 1; chk_to = 200;
        for (c = 0; c < 40; c++) begin
            step(1'b1, word_at(c));
            observe(c + 1);
            if (nh >= 4) break;
        end
        check("mrst_first_head_cyc", 64'(head_cyc[1]), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
